controle_multiciclo: RTL and testbench

- Main control unit (state machine) of the multicycle MIPS datapath.
- Produces `alu_op[1:0]` and all datapath mux/write-enable signals consumed by `ula_control`, the register file, PC and memory.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Handshakes with a variable-latency unified memory via `mem_ready`.

---
 rtl/controle_multiciclo_pkg.sv | 74 +++++++
 rtl/controle_multiciclo_if.sv | 41 ++++
 rtl/controle_multiciclo_mem_wait_timer.sv | 40 ++++
 rtl/controle_multiciclo.sv | 203 ++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/controle_multiciclo_pkg.sv
// rtl/controle_multiciclo_pkg.sv - shared encodings for the multicycle MIPS control unit
// Purpose: state codes, opcode/funct constants, ALUOp codes and datapath mux
//          encodings used by the controller, its interface and its testbench.
// Ports:   none (package).
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12,
    S_JAL       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // addi plus the contiguous slti..lui block
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || ((op >= OP_SLTI) && (op <= OP_LUI));
  endfunction

  // logical immediates take a zero-extended operand
  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// rtl/controle_multiciclo_if.sv - control bus between the controller and the datapath
// Purpose: bundles instruction fields and memory handshake (into the controller)
//          with every datapath control line (out of the controller).
// Ports:   none; modport master = controller side, slave = datapath/memory side.
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       trap;
  logic [3:0] state_out;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
           mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, ext_zero, alu_op, instr_done, trap, state_out
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
           mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, ext_zero, alu_op, instr_done, trap, state_out
  );
endinterface

// File: rtl/controle_multiciclo_mem_wait_timer.sv
// rtl/controle_multiciclo_mem_wait_timer.sv - memory wait-state counter with timeout flag
// Purpose: counts cycles spent waiting on mem_ready; flags when the count has
//          reached MEM_TIMEOUT. Saturates there so the flag stays up.
// Ports:   clk, reset (sync, active-high); clear restarts the count;
//          wait_cycle adds one; timeout is high while count == MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wait_cycle,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  assign timeout = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wait_cycle && !timeout) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle MIPS main control FSM
// Purpose: sequences fetch/decode/execute/memory/writeback, drives every
//          datapath mux and write enable, waits on a variable-latency memory
//          and traps on illegal opcodes or memory timeouts.
// Ports:   clk; reset (sync, active-high); bus (master modport): opcode, funct,
//          mem_ready in; PC/memory/IR/regfile/ALU controls, instr_done, trap,
//          state_out out.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input logic                   clk,
  input logic                   reset,
  controle_multiciclo_if.master bus
);

  state_t state_q, state_d;
  logic   in_wait;
  logic   timeout;

  logic       pc_write_c, pc_write_cond_c, branch_ne_c, i_or_d_c, mem_read_c;
  logic       mem_write_c, ir_write_c, reg_write_c, alu_src_a_c, ext_zero_c;
  logic       instr_done_c;
  logic [1:0] pc_source_c, reg_dst_c, mem_to_reg_c, alu_src_b_c, alu_op_c;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);

  // Any state change clears the count, which covers entry into each wait state.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_d != state_q),
    .wait_cycle (in_wait && !bus.mem_ready),
    .timeout    (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_TRAP;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = (bus.funct == FUNCT_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = is_itype(bus.opcode) ? S_I_EXEC : S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready)  state_d = S_MEM_WB;
        else if (timeout)   state_d = S_TRAP;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (timeout)   state_d = S_TRAP;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR, S_JAL:
                   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    branch_ne_c     = 1'b0;
    pc_source_c     = PCSRC_ALU;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = REGDST_RT;
    mem_to_reg_c    = MTR_ALUOUT;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = SRCB_B;
    ext_zero_c      = 1'b0;
    alu_op_c        = ALUOP_ADD;
    instr_done_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        // IR and PC+4 are committed only when the word actually arrives
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
      end
      S_DECODE: alu_src_b_c = SRCB_BROFF;
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = MTR_MDR;
        instr_done_c = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = bus.mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = REGDST_RD;
        instr_done_c = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        // alu_op/ext_zero stay put across both states so ALUOut is stable
        alu_op_c   = (bus.opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_ITYPE;
        ext_zero_c = is_zext(bus.opcode);
        if (state_q == S_I_EXEC) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
        end else begin
          reg_write_c  = 1'b1;
          instr_done_c = 1'b1;
        end
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = ALUOP_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = PCSRC_ALUOUT;
        branch_ne_c     = (bus.opcode == OP_BNE);
        instr_done_c    = 1'b1;
      end
      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source_c  = PCSRC_JUMP;
        instr_done_c = 1'b1;
      end
      S_JR: begin
        pc_write_c   = 1'b1;
        pc_source_c  = PCSRC_RS;
        instr_done_c = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value
        reg_write_c  = 1'b1;
        reg_dst_c    = REGDST_RA;
        mem_to_reg_c = MTR_PC;
        pc_write_c   = 1'b1;
        pc_source_c  = PCSRC_JUMP;
        instr_done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset may land mid-instruction while state_q still holds a write state;
  // gating the enables keeps that cycle from committing anything.
  assign bus.pc_write      = pc_write_c      & ~reset;
  assign bus.pc_write_cond = pc_write_cond_c & ~reset;
  assign bus.ir_write      = ir_write_c      & ~reset;
  assign bus.reg_write     = reg_write_c     & ~reset;
  assign bus.mem_write     = mem_write_c     & ~reset;
  assign bus.instr_done    = instr_done_c    & ~reset;
  assign bus.branch_ne     = branch_ne_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.i_or_d        = i_or_d_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.ext_zero      = ext_zero_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.trap          = (state_q == S_TRAP);
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - self-checking bench for controle_multiciclo
// Purpose: directed and randomized instruction sequences checked cycle by cycle
//          against a path/output table built from the instruction rules.
// Ports:   none (top-level bench).
module tb_controle_multiciclo;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  controle_multiciclo_if ifc();

  controle_multiciclo #(
    .MEM_TIMEOUT (255),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  int       path[$];
  bit       rdys[$];
  logic [5:0] legal_ops [14] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                                 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] obs_ctl();
    return {ifc.pc_write, ifc.pc_write_cond, ifc.branch_ne, ifc.pc_source,
            ifc.i_or_d, ifc.mem_read, ifc.mem_write, ifc.ir_write, ifc.reg_write,
            ifc.reg_dst, ifc.mem_to_reg, ifc.alu_src_a, ifc.alu_src_b,
            ifc.ext_zero, ifc.alu_op, ifc.instr_done};
  endfunction

  // Expected control word for one cycle, straight from the per-state rules.
  function automatic logic [20:0] exp_ctl(input int st, input logic [5:0] op, input bit rdy);
    logic pcw = 0, pwc = 0, bne = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0;
    logic sa = 0, ez = 0, done = 0;
    logic [1:0] pcs = 0, rd = 0, mtr = 0, sb = 0, aop = 0;
    if (st == 0)  begin mr = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
    if (st == 1)  sb = 2'd3;
    if (st == 2)  begin sa = 1; sb = 2'd2; end
    if (st == 3)  begin mr = 1; iord = 1; end
    if (st == 4)  begin rw = 1; mtr = 2'd1; done = 1; end
    if (st == 5)  begin mw = 1; iord = 1; done = rdy; end
    if (st == 6)  begin sa = 1; aop = 2'd2; end
    if (st == 7)  begin rw = 1; rd = 2'd1; done = 1; end
    if (st == 8)  begin sa = 1; aop = 2'd1; pwc = 1; pcs = 2'd1; bne = (op == 6'h05); done = 1; end
    if (st == 9)  begin pcw = 1; pcs = 2'd2; done = 1; end
    if (st == 10 || st == 11) begin
      aop = (op == 6'h08) ? 2'd0 : 2'd3;
      ez  = (op >= 6'h0C && op <= 6'h0E);
      if (st == 10) begin sa = 1; sb = 2'd2; end
      else          begin rw = 1; done = 1; end
    end
    if (st == 12) begin pcw = 1; pcs = 2'd3; done = 1; end
    if (st == 13) begin rw = 1; rd = 2'd2; mtr = 2'd2; pcw = 1; pcs = 2'd2; done = 1; end
    return {pcw, pwc, bne, pcs, iord, mr, mw, irw, rw, rd, mtr, sa, sb, ez, aop, done};
  endfunction

  task automatic push(input int st, input int waits, input bit last_rdy);
    for (int i = 0; i < waits; i++) begin path.push_back(st); rdys.push_back(1'b0); end
    path.push_back(st);
    rdys.push_back(last_rdy);
  endtask

  // Expected state walk: fetch with fw not-ready cycles, then class-specific tail.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    path.delete();
    rdys.delete();
    push(0, fw, 1'b1);
    push(1, 0, 1'($urandom_range(0, 1)));
    case (op)
      6'h00: if (fn == 6'h08) push(12, 0, 1'b1);
             else begin push(6, 0, 1'b1); push(7, 0, 1'b0); end
      6'h23: begin push(2, 0, 1'b0); push(3, mw, 1'b1); push(4, 0, 1'b1); end
      6'h2B: begin push(2, 0, 1'b0); push(5, mw, 1'b1); end
      6'h04, 6'h05: push(8, 0, 1'b0);
      6'h02: push(9, 0, 1'b1);
      6'h03: push(13, 0, 1'b0);
      default: begin push(10, 0, 1'b1); push(11, 0, 1'b0); end
    endcase
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw);
    int dones = 0;
    build_path(op, fn, fw, mw);
    ifc.opcode = op;
    ifc.funct  = fn;
    for (int i = 0; i < path.size(); i++) begin
      ifc.mem_ready = rdys[i];
      @(negedge clk);
      chk($sformatf("%s state[%0d]", name, i), 32'(ifc.state_out), 32'(path[i]));
      chk($sformatf("%s ctl st%0d", name, path[i]), 32'(obs_ctl()),
          32'(exp_ctl(path[i], op, rdys[i])));
      if (ifc.instr_done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s instr_done count", name), 32'(dones), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    ifc.opcode    = 6'h00;
    ifc.funct     = 6'h00;
    ifc.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(ifc.state_out), 32'd0);
    chk("reset trap", 32'(ifc.trap), 32'd0);
    chk("reset enables", 32'({ifc.pc_write, ifc.pc_write_cond, ifc.ir_write,
                              ifc.reg_write, ifc.mem_write, ifc.instr_done}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr("add", 6'h00, 6'h20, 0, 0);
    run_instr("lw", 6'h23, 6'h00, 3, 2);
    run_instr("bne", 6'h05, 6'h00, 0, 0);
    run_instr("beq", 6'h04, 6'h00, 1, 0);
    run_instr("ori", 6'h0D, 6'h00, 0, 0);
    run_instr("addi", 6'h08, 6'h00, 0, 0);
    run_instr("jal", 6'h03, 6'h00, 0, 0);
    run_instr("jr", 6'h00, 6'h08, 0, 0);
    run_instr("j", 6'h02, 6'h00, 0, 0);
    run_instr("fetch_ready_at_limit", 6'h00, 6'h22, 255, 0);
    run_instr("sw_ready_at_limit", 6'h2B, 6'h00, 0, 255);
    run_instr("lw_ready_at_limit", 6'h23, 6'h00, 0, 255);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] rop;
      rop = legal_ops[$urandom_range(0, 13)];
      run_instr($sformatf("rand%0d op%0h", n, rop), rop, 6'($urandom_range(0, 63)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset landing in the middle of a store
    ifc.opcode    = 6'h2B;
    ifc.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    chk("sw wait state", 32'(ifc.state_out), 32'd5);
    chk("sw mem_write before reset", 32'(ifc.mem_write), 32'd1);
    @(posedge clk); #1;
    reset         = 1'b1;
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    chk("reset mid-sw mem_write", 32'(ifc.mem_write), 32'd0);
    chk("reset mid-sw instr_done", 32'(ifc.instr_done), 32'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    chk("after reset state", 32'(ifc.state_out), 32'd0);
    @(posedge clk); #1;
    run_instr("post-reset add", 6'h00, 6'h21, 0, 0);

    // illegal opcode traps and stays trapped
    ifc.opcode    = 6'h3F;
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    chk("illegal fetch", 32'(ifc.state_out), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("illegal decode", 32'(ifc.state_out), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      ifc.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("illegal trap state %0d", i), 32'(ifc.state_out), 32'd14);
      chk($sformatf("illegal trap flag %0d", i), 32'(ifc.trap), 32'd1);
      chk($sformatf("illegal trap ctl %0d", i), 32'(obs_ctl()), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("trap cleared by reset", 32'(ifc.trap), 32'd0);
    chk("state after trap reset", 32'(ifc.state_out), 32'd0);

    // mem_ready stuck low: 255 counted wait cycles, then the timeout cycle traps
    ifc.mem_ready = 1'b0;
    ifc.opcode    = 6'h00;
    @(posedge clk); #1;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      if (ifc.state_out !== 4'd0) chk($sformatf("timeout still fetching %0d", i),
                                      32'(ifc.state_out), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout state", 32'(ifc.state_out), 32'd14);
    chk("timeout trap", 32'(ifc.trap), 32'd1);
    ifc.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout trap sticky", 32'(ifc.trap), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
